// File: rtl/fsm_event_cond.sv
// fsm_event_cond
//   Conditions raw, asynchronous start/done/fault levels into the clean
//   inputs the supervisory FSM expects. Each channel is synchronised with
//   two flops, debounced, and edge-detected. Start and done become
//   single-cycle pulses. Fault becomes a sticky level. A busy-timeout
//   watchdog watches the FSM's busy feedback and raises a fault if done
//   never arrives.
//
// Ports
//   clk             system clock; all state changes on the rising edge
//   rst_n           asynchronous active-low reset
//   i_raw_start     asynchronous start request (level)
//   i_raw_done      asynchronous completion indication (level)
//   i_raw_fault     asynchronous external fault (level, active-high)
//   i_fault_clr     synchronous single-cycle fault-latch clear request
//   i_fsm_busy      busy flag fed back from the FSM
//   o_in_start      one-cycle start pulse; suppressed while a fault is latched
//   o_in_done       one-cycle done pulse
//   o_in_fault      sticky fault level (OR of the fault cause bits)
//   o_wdt_expired   one-cycle pulse on watchdog timeout
//   o_fault_src     sticky fault cause: bit0 external fault, bit1 watchdog
//
// Parameters
//   DEB_CYCLES  consecutive synchronised cycles a new level must hold (1..255)
//   WDT_CYCLES  busy cycles allowed before a watchdog fault; 0 disables it
//   WDT_W       watchdog counter width; WDT_CYCLES must fit in it

module fsm_event_cond #(
  parameter int DEB_CYCLES = 4,
  parameter int WDT_CYCLES = 1000,
  parameter int WDT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_raw_start,
  input  logic       i_raw_done,
  input  logic       i_raw_fault,
  input  logic       i_fault_clr,
  input  logic       i_fsm_busy,
  output logic       o_in_start,
  output logic       o_in_done,
  output logic       o_in_fault,
  output logic       o_wdt_expired,
  output logic [1:0] o_fault_src
);

  // Channel index map used by all the per-channel vectors below.
  localparam int CH_START = 0;
  localparam int CH_DONE  = 1;
  localparam int CH_FAULT = 2;

  localparam logic [7:0]       DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(WDT_CYCLES);
  localparam bit               WDT_EN    = (WDT_CYCLES > 0);

  logic [2:0]       w_raw;
  logic [2:0]       r_meta;
  logic [2:0]       r_sync;
  logic [2:0]       r_stable;
  logic [2:0]       r_stableDly;
  logic [7:0]       r_debCnt [3];
  logic [WDT_W-1:0] r_wdtCnt;
  logic [1:0]       w_srcNext;

  assign w_raw = {i_raw_fault, i_raw_done, i_raw_start};

  // Two-flop synchroniser for every raw channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  // Debounce: a channel only adopts a new synchronised level after it has
  // differed from the accepted level for DEB_CYCLES consecutive cycles.
  // Any cycle of agreement restarts the count, so short glitches vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int c = 0; c < 3; c++) r_debCnt[c] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (r_sync[c] == r_stable[c]) begin
          r_debCnt[c] <= '0;
        end else if (r_debCnt[c] == DEB_LAST) begin
          r_stable[c] <= r_sync[c];
          r_debCnt[c] <= '0;
        end else begin
          r_debCnt[c] <= r_debCnt[c] + 8'd1;
        end
      end
    end
  end

  // Rising-edge detect on the debounced start/done levels. A start that
  // arrives while a fault is latched is dropped outright, not deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stableDly <= '0;
      o_in_start  <= 1'b0;
      o_in_done   <= 1'b0;
    end else begin
      r_stableDly <= r_stable;
      o_in_start  <= r_stable[CH_START] & ~r_stableDly[CH_START] & ~o_in_fault;
      o_in_done   <= r_stable[CH_DONE] & ~r_stableDly[CH_DONE];
    end
  end

  // Busy-timeout watchdog. The count restarts whenever the FSM is idle or
  // a done pulse is delivered. On reaching the limit it fires once and
  // then parks at the limit until the next restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdtCnt      <= '0;
      o_wdt_expired <= 1'b0;
    end else if (!WDT_EN || !i_fsm_busy || o_in_done) begin
      r_wdtCnt      <= '0;
      o_wdt_expired <= 1'b0;
    end else if (r_wdtCnt < WDT_LIMIT) begin
      r_wdtCnt      <= r_wdtCnt + WDT_W'(1);
      o_wdt_expired <= (r_wdtCnt == WDT_LIMIT - WDT_W'(1));
    end else begin
      o_wdt_expired <= 1'b0;
    end
  end

  // Fault-cause next state. A clear is refused while the external fault
  // is still asserted. Set terms are applied after the clear so that a
  // simultaneous set always survives.
  always_comb begin
    w_srcNext = o_fault_src;
    if (i_fault_clr && !r_stable[CH_FAULT]) w_srcNext = 2'b00;
    if (r_stable[CH_FAULT]) w_srcNext[0] = 1'b1;
    if (o_wdt_expired) w_srcNext[1] = 1'b1;
  end

  // in_fault is registered from the same next state, so it moves in step
  // with fault_src.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fault_src <= 2'b00;
      o_in_fault  <= 1'b0;
    end else begin
      o_fault_src <= w_srcNext;
      o_in_fault  <= |w_srcNext;
    end
  end

endmodule

// File: tb/tb_fsm_event_cond.sv
// tb_fsm_event_cond
//   Self-checking bench for fsm_event_cond with DEB_CYCLES=4 and
//   WDT_CYCLES=20. It covers a vector table, directed multi-cycle corner
//   cases, and a randomised run against a timestamp-based reference model.

module tb_fsm_event_cond;

  localparam int DEB = 4;
  localparam int WDT = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tbRawStart, tbRawDone, tbRawFault, tbFaultClr, tbBusy;
  logic       o_in_start, o_in_done, o_in_fault, o_wdt_expired;
  logic [1:0] o_fault_src;

  int nTests = 0;
  int nFail  = 0;

  fsm_event_cond #(.DEB_CYCLES(DEB), .WDT_CYCLES(WDT), .WDT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_raw_start  (tbRawStart),
    .i_raw_done   (tbRawDone),
    .i_raw_fault  (tbRawFault),
    .i_fault_clr  (tbFaultClr),
    .i_fsm_busy   (tbBusy),
    .o_in_start   (o_in_start),
    .o_in_done    (o_in_done),
    .o_in_fault   (o_in_fault),
    .o_wdt_expired(o_wdt_expired),
    .o_fault_src  (o_fault_src)
  );

  always #5 clk = ~clk;

  // Reference model. It tracks, per channel, the cycle at which the
  // synchronised level started disagreeing with the accepted level, and
  // the cycle at which the current busy stretch began. Acceptance and
  // expiry are decided from elapsed-cycle arithmetic on those timestamps.
  int         mCyc;
  int         mSince [3];
  int         mBusyFrom;
  logic [2:0] mS1, mSy, mSt, mRose;
  logic       mStart, mDone, mExp, mInFault;
  logic [1:0] mSrc;

  function automatic logic [1:0] faultNext(input logic [1:0] src, input logic clr,
                                           input logic extFault, input logic expired);
    logic clrOk;
    clrOk = clr && !extFault;
    return {expired | (src[1] & ~clrOk), extFault | (src[0] & ~clrOk)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCyc      <= 0;
      mBusyFrom <= 0;
      mS1       <= '0;
      mSy       <= '0;
      mSt       <= '0;
      mRose     <= '0;
      mStart    <= 1'b0;
      mDone     <= 1'b0;
      mExp      <= 1'b0;
      mInFault  <= 1'b0;
      mSrc      <= 2'b00;
      for (int c = 0; c < 3; c++) mSince[c] <= 0;
    end else begin
      mCyc <= mCyc + 1;
      mS1  <= {tbRawFault, tbRawDone, tbRawStart};
      mSy  <= mS1;
      for (int c = 0; c < 3; c++) begin
        if (mSy[c] == mSt[c]) begin
          mSince[c] <= mCyc + 1;
          mRose[c]  <= 1'b0;
        end else if (mCyc - mSince[c] + 1 >= DEB) begin
          mSt[c]    <= mSy[c];
          mSince[c] <= mCyc + 1;
          mRose[c]  <= mSy[c];
        end else begin
          mRose[c]  <= 1'b0;
        end
      end
      mStart <= mRose[0] & ~mInFault;
      mDone  <= mRose[1];
      if (!tbBusy || mDone) begin
        mBusyFrom <= mCyc + 1;
        mExp      <= 1'b0;
      end else begin
        mExp <= (mCyc - mBusyFrom + 1 == WDT);
      end
      mSrc     <= faultNext(mSrc, tbFaultClr, mSt[2], mExp);
      mInFault <= |faultNext(mSrc, tbFaultClr, mSt[2], mExp);
    end
  end

  typedef struct {
    logic rs, rd, rf, busy, clr;
    int   cycles;
    int   expStart;
    int   expDone;
    logic expFault;
  } vec_t;

  vec_t vecs [15];

  task automatic applyStimulus(input logic rs, input logic rd, input logic rf,
                               input logic busy, input logic clr);
    tbRawStart = rs;
    tbRawDone  = rd;
    tbRawFault = rf;
    tbBusy     = busy;
    tbFaultClr = clr;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outVec();
    return {2'b00, o_in_start, o_in_done, o_in_fault, o_wdt_expired, o_fault_src};
  endfunction

  initial begin
    int sCnt, dCnt;
    int hS, hD, hF, hB;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1, 0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  3, 0, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  4, 0, 0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10, 1, 1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10, 0, 0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  3, 0, 0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  1, 0, 0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b0};

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    step(3);
    checkOutput("reset_state", outVec(), 8'h00);
    rst_n = 1'b1;

    // Vector table: each row is held for its cycle count, then the pulses
    // seen during the row and the final fault level are compared.
    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].rs, vecs[v].rd, vecs[v].rf, vecs[v].busy, vecs[v].clr);
      sCnt = 0;
      dCnt = 0;
      for (int i = 0; i < vecs[v].cycles; i++) begin
        step(1);
        sCnt += int'(o_in_start);
        dCnt += int'(o_in_done);
      end
      checkOutput($sformatf("vec%0d_start_cnt", v), 8'(sCnt), 8'(vecs[v].expStart));
      checkOutput($sformatf("vec%0d_done_cnt", v), 8'(dCnt), 8'(vecs[v].expDone));
      checkOutput($sformatf("vec%0d_fault", v), {7'd0, o_in_fault}, {7'd0, vecs[v].expFault});
    end

    // Start latency: the pulse lands DEB+2 edges after the first sampling edge.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      checkOutput($sformatf("start_lat_e%0d", i), {7'd0, o_in_start}, {7'd0, 1'(i == DEB + 3)});
    end
    applyStimulus(0, 0, 0, 0, 0);
    step(10);

    // Watchdog expiry with busy held and no done.
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 1; i <= 25; i++) begin
      step(1);
      checkOutput($sformatf("wdt_e%0d", i), {7'd0, o_wdt_expired}, {7'd0, 1'(i == WDT)});
      if (i == WDT + 1) begin
        checkOutput("wdt_src", {6'd0, o_fault_src}, 8'h02);
        checkOutput("wdt_fault", {7'd0, o_in_fault}, 8'h01);
      end
    end
    applyStimulus(0, 0, 0, 0, 1);
    step(1);
    checkOutput("wdt_clr", {7'd0, o_in_fault}, 8'h00);

    // A done pulse mid-busy restarts the watchdog count.
    applyStimulus(0, 1, 0, 1, 0);
    for (int i = 1; i <= 32; i++) begin
      step(1);
      checkOutput($sformatf("wdt_done_e%0d", i), {7'd0, o_wdt_expired}, {7'd0, 1'(i == 28)});
      checkOutput($sformatf("done_e%0d", i), {7'd0, o_in_done}, {7'd0, 1'(i == DEB + 3)});
    end
    applyStimulus(0, 0, 0, 0, 1);
    step(1);
    checkOutput("wdt_done_clr", {7'd0, o_in_fault}, 8'h00);
    applyStimulus(0, 0, 0, 0, 0);
    step(10);

    // raw_start held through reset gives exactly one pulse after release.
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    step(3);
    checkOutput("in_reset_outputs", outVec(), 8'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      checkOutput($sformatf("post_rst_start_e%0d", i), {7'd0, o_in_start}, {7'd0, 1'(i == DEB + 3)});
    end
    applyStimulus(0, 0, 0, 0, 0);
    step(10);

    // Asynchronous reset mid-debounce with a fault latched.
    applyStimulus(0, 0, 1, 0, 0);
    step(10);
    checkOutput("pre_rst_fault", {6'd0, o_fault_src}, 8'h01);
    applyStimulus(1, 0, 1, 0, 0);
    step(3);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_outputs", outVec(), 8'h00);
    applyStimulus(0, 0, 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    sCnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      sCnt += int'(o_in_start) + int'(o_in_fault);
    end
    checkOutput("no_pulse_after_rst", 8'(sCnt), 8'h00);

    // Randomised run against the reference model, from a fresh reset.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    hS = 0; hD = 0; hF = 0; hB = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hS == 0) begin tbRawStart = 1'($urandom_range(0, 1)); hS = $urandom_range(1, 7); end
      if (hD == 0) begin tbRawDone  = 1'($urandom_range(0, 1)); hD = $urandom_range(1, 7); end
      if (hF == 0) begin tbRawFault = 1'($urandom_range(0, 3) == 0); hF = $urandom_range(1, 12); end
      if (hB == 0) begin tbBusy     = 1'($urandom_range(0, 1)); hB = $urandom_range(1, 45); end
      tbFaultClr = 1'($urandom_range(0, 5) == 0);
      hS--; hD--; hF--; hB--;
      step(1);
      checkOutput($sformatf("rand_c%0d", n), outVec(),
                  {2'b00, mStart, mDone, mInFault, mExp, mSrc});
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
